// File: rtl/dht11_ctrl.sv
// dht11_ctrl: sequences DHT11 reader attempts (kick, arm, run, check),
// validates each reading, retries failed attempts after an idle gap, and
// holds the last good reading for the host.
module dht11_ctrl #(
  parameter int GAP_CYCLES  = 100000000,
  parameter int WDOG_CYCLES = 10000000,
  parameter int MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       auto_en,
  output logic       sens_en,
  output logic       sens_rst,
  input  logic       sens_wait,
  input  logic       sens_error,
  input  logic [7:0] sens_hum_int,
  input  logic [7:0] sens_hum_float,
  input  logic [7:0] sens_temp_int,
  input  logic [7:0] sens_temp_float,
  input  logic [7:0] sens_crc,
  output logic [7:0] hum_int,
  output logic [7:0] hum_float,
  output logic [7:0] temp_int,
  output logic [7:0] temp_float,
  output logic       busy,
  output logic       done,
  output logic [1:0] status,
  output logic [2:0] attempts
);

  localparam int          WDW      = $clog2(WDOG_CYCLES + 1);
  localparam logic [26:0] GAP_LAST = 27'(GAP_CYCLES - 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(WDOG_CYCLES - 1);
  // attempt counter is one bit wider than the port so MAX_RETRY=7 still
  // reaches its final attempt (8); the reported value saturates at 7
  localparam logic [3:0]  MAX_R    = 4'(MAX_RETRY);

  typedef enum logic [2:0] {IDLE, KICK, ARM, RUN, CHECK, GAP} state_t;

  state_t         state, nxt;
  logic           pending, err_seen, to_flt, retry;
  logic [1:0]     arm_cnt;
  logic [WDW-1:0] wd_cnt;
  logic [26:0]    gap_cnt;
  logic [3:0]     att_cnt;
  logic [7:0]     sum;
  logic [1:0]     code;

  // checksum is an 8-bit wrapping sum of the four data bytes
  assign sum = sens_hum_int + sens_hum_float + sens_temp_int + sens_temp_float;

  // attempt result with timeout taking priority over reader error over crc
  always_comb begin
    code = 2'b00;
    if (to_flt)               code = 2'b11;
    else if (err_seen)        code = 2'b10;
    else if (sum != sens_crc) code = 2'b01;
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  // next-state logic
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (req || pending) nxt = KICK;
      KICK:  nxt = ARM;
      ARM:   if (sens_wait) nxt = RUN;
             else if (arm_cnt == 2'd3) nxt = CHECK;
      RUN:   if (!sens_wait || wd_cnt == WD_LAST) nxt = CHECK;
      CHECK: nxt = GAP;
      GAP:   if (gap_cnt == GAP_LAST) nxt = (retry || auto_en) ? KICK : IDLE;
      default: nxt = IDLE;
    endcase
  end

  // sensor controls and busy decoded from state
  always_comb begin
    sens_en  = (state == KICK) || (state == ARM) || (state == RUN) || (state == CHECK);
    sens_rst = (state == KICK);
    busy     = (state != IDLE);
  end

  // counters, flags and registered results
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending    <= 1'b0;
      err_seen   <= 1'b0;
      to_flt     <= 1'b0;
      retry      <= 1'b0;
      arm_cnt    <= '0;
      wd_cnt     <= '0;
      gap_cnt    <= '0;
      att_cnt    <= '0;
      done       <= 1'b0;
      status     <= 2'b00;
      attempts   <= 3'd0;
      hum_int    <= 8'd0;
      hum_float  <= 8'd0;
      temp_int   <= 8'd0;
      temp_float <= 8'd0;
    end else begin
      done <= 1'b0;
      // a request while busy is remembered once and served from IDLE
      if (state == IDLE) pending <= 1'b0;
      else if (req)      pending <= 1'b1;
      case (state)
        IDLE: if (req || pending) att_cnt <= 4'd1;
        KICK: begin
          err_seen <= 1'b0;
          to_flt   <= 1'b0;
          arm_cnt  <= '0;
          wd_cnt   <= '0;
        end
        ARM: if (!sens_wait) begin
          arm_cnt <= arm_cnt + 2'd1;
          if (arm_cnt == 2'd3) to_flt <= 1'b1;
        end
        RUN: begin
          if (sens_error) err_seen <= 1'b1;
          if (sens_wait) begin
            wd_cnt <= wd_cnt + 1'b1;
            if (wd_cnt == WD_LAST) to_flt <= 1'b1;
          end
        end
        CHECK: begin
          gap_cnt <= '0;
          if (code == 2'b00) begin
            hum_int    <= sens_hum_int;
            hum_float  <= sens_hum_float;
            temp_int   <= sens_temp_int;
            temp_float <= sens_temp_float;
            status     <= 2'b00;
            done       <= 1'b1;
            attempts   <= (att_cnt > 4'd7) ? 3'd7 : att_cnt[2:0];
            retry      <= 1'b0;
          end else if (att_cnt <= MAX_R) begin
            att_cnt <= att_cnt + 4'd1;
            retry   <= 1'b1;
          end else begin
            status   <= code;
            done     <= 1'b1;
            attempts <= (att_cnt > 4'd7) ? 3'd7 : att_cnt[2:0];
            retry    <= 1'b0;
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + 27'd1;
          // periodic mode starts a fresh transaction
          if (gap_cnt == GAP_LAST && !retry && auto_en) att_cnt <= 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dht11_ctrl.sv
// tb_dht11_ctrl: directed scenarios against a behavioural DHT11 reader;
// expected transaction results are queued and checked on each done pulse.
module tb_dht11_ctrl;

  localparam int M_NORMAL = 0, M_ERR = 1, M_HANG = 2, M_NOWAIT = 3;

  logic       clk = 0, rst = 0, req = 0, auto_en = 0;
  logic       sens_en, sens_rst;
  logic       sens_wait = 0, sens_error = 0;
  logic [7:0] sens_hum_int = 0, sens_hum_float = 0, sens_temp_int = 0;
  logic [7:0] sens_temp_float = 0, sens_crc = 0;
  logic [7:0] hum_int, hum_float, temp_int, temp_float;
  logic       busy, done;
  logic [1:0] status;
  logic [2:0] attempts;

  typedef struct packed {
    logic [1:0] st;
    logic [2:0] att;
    logic [7:0] hi, hf, ti, tf;
  } exp_t;

  exp_t q[$];
  int   checks = 0, failures = 0, done_cnt = 0;
  int   modes[8];
  int   att_idx = 0;

  dht11_ctrl #(.GAP_CYCLES(20), .WDOG_CYCLES(50), .MAX_RETRY(2)) dut (
    .clk(clk), .rst(rst), .req(req), .auto_en(auto_en),
    .sens_en(sens_en), .sens_rst(sens_rst),
    .sens_wait(sens_wait), .sens_error(sens_error),
    .sens_hum_int(sens_hum_int), .sens_hum_float(sens_hum_float),
    .sens_temp_int(sens_temp_int), .sens_temp_float(sens_temp_float),
    .sens_crc(sens_crc),
    .hum_int(hum_int), .hum_float(hum_float), .temp_int(temp_int),
    .temp_float(temp_float), .busy(busy), .done(done),
    .status(status), .attempts(attempts)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] st, input logic [2:0] att,
                      input logic [7:0] hi, hf, ti, tf);
    exp_t e;
    e = '{st, att, hi, hf, ti, tf};
    q.push_back(e);
  endtask

  task automatic set_data(input logic [7:0] hi, hf, ti, tf, crc);
    sens_hum_int = hi; sens_hum_float = hf; sens_temp_int = ti;
    sens_temp_float = tf; sens_crc = crc;
  endtask

  task automatic set_modes(input int m0, input int mr);
    modes[0] = m0;
    for (int i = 1; i < 8; i++) modes[i] = mr;
    att_idx = 0;
  endtask

  task automatic pulse_req();
    @(negedge clk); req = 1;
    @(negedge clk); req = 0;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !busy) begin ok = 1; break; end
    end
    chk({name, "_complete"}, int'(ok), 1);
  endtask

  task automatic wait_wait_high(input string name);
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sens_wait) begin ok = 1; break; end
    end
    chk({name, "_wait_high"}, int'(ok), 1);
  endtask

  task automatic reset_checks(input string name);
    chk({name, "_sens_en"}, int'(sens_en), 0);
    chk({name, "_sens_rst"}, int'(sens_rst), 0);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_done"}, int'(done), 0);
    chk({name, "_status"}, int'(status), 0);
    chk({name, "_attempts"}, int'(attempts), 0);
    chk({name, "_data"}, int'({hum_int, hum_float, temp_int, temp_float}), 0);
  endtask

  // reader model: reacts to each kick according to the per-attempt mode
  initial begin
    int m;
    forever begin
      @(negedge clk);
      if (sens_rst) begin
        m = modes[att_idx % 8];
        att_idx++;
        if (m != M_NOWAIT) begin
          @(negedge clk);
          sens_wait = 1;
          if (m == M_HANG) begin
            for (int i = 0; i < 200; i++) begin
              @(negedge clk);
              if (!sens_en) break;
            end
          end else begin
            repeat (3) @(negedge clk);
            if (m == M_ERR) sens_error = 1;
            repeat (3) @(negedge clk);
            sens_error = 0;
            repeat (4) @(negedge clk);
          end
          sens_wait = 0;
        end
      end
    end
  end

  // monitor: every done pulse consumes one expected result
  initial begin
    exp_t e;
    logic prev_done = 0;
    forever begin
      @(negedge clk);
      if (!rst) prev_done = 0;
      else begin
        if (done) begin
          done_cnt++;
          chk("done_one_cycle", int'(prev_done), 0);
          if (q.size() == 0) chk("unexpected_done", q.size(), 1);
          else begin
            e = q.pop_front();
            chk("status", int'(status), int'(e.st));
            chk("attempts", int'(attempts), int'(e.att));
            chk("hum_int", int'(hum_int), int'(e.hi));
            chk("hum_float", int'(hum_float), int'(e.hf));
            chk("temp_int", int'(temp_int), int'(e.ti));
            chk("temp_float", int'(temp_float), int'(e.tf));
          end
        end
        prev_done = done;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n, base;
    bit ok;
    set_modes(M_NORMAL, M_NORMAL);
    repeat (3) @(negedge clk);
    reset_checks("reset");
    rst = 1;
    repeat (2) @(negedge clk);

    // good reading, then measure gap length from done to idle
    set_data(8'h37, 8'h00, 8'h19, 8'h05, 8'h55);
    set_modes(M_NORMAL, M_NORMAL);
    push(2'b00, 3'd1, 8'h37, 8'h00, 8'h19, 8'h05);
    pulse_req();
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
    end
    chk("good_done_seen", int'(ok), 1);
    n = 0;
    while (busy && n < 100) begin n++; @(negedge clk); end
    chk("gap_len", n, 20);
    wait_idle("good");

    // checksum wrong every attempt: data must stay at prior reading
    set_data(8'h40, 8'h01, 8'h10, 8'h02, 8'h54);
    set_modes(M_NORMAL, M_NORMAL);
    base = done_cnt;
    push(2'b01, 3'd3, 8'h37, 8'h00, 8'h19, 8'h05);
    pulse_req();
    wait_idle("badcrc");
    chk("badcrc_done_count", done_cnt - base, 1);

    // reader error on first attempt, good second attempt
    set_data(8'h3C, 8'h00, 8'h1A, 8'h00, 8'h56);
    set_modes(M_ERR, M_NORMAL);
    push(2'b00, 3'd2, 8'h3C, 8'h00, 8'h1A, 8'h00);
    pulse_req();
    wait_idle("err_retry");

    // sens_wait stuck high: watchdog every attempt
    set_modes(M_HANG, M_HANG);
    push(2'b11, 3'd3, 8'h3C, 8'h00, 8'h1A, 8'h00);
    pulse_req();
    wait_idle("wdog");
    chk("wdog_attempts_used", att_idx, 3);

    // sens_wait never rises: arm timeout every attempt
    set_modes(M_NOWAIT, M_NOWAIT);
    push(2'b11, 3'd3, 8'h3C, 8'h00, 8'h1A, 8'h00);
    pulse_req();
    wait_idle("arm_timeout");

    // two reqs during RUN collapse into one pending transaction
    set_data(8'h20, 8'h05, 8'h15, 8'h03, 8'h3D);
    set_modes(M_NORMAL, M_NORMAL);
    base = done_cnt;
    push(2'b00, 3'd1, 8'h20, 8'h05, 8'h15, 8'h03);
    pulse_req();
    wait_wait_high("pend");
    pulse_req();
    repeat (2) @(negedge clk);
    pulse_req();
    push(2'b00, 3'd1, 8'h20, 8'h05, 8'h15, 8'h03);
    wait_idle("pending");
    chk("pending_done_count", done_cnt - base, 2);

    // periodic mode: three back-to-back transactions, stop after the third
    set_modes(M_NORMAL, M_NORMAL);
    base = done_cnt;
    for (int i = 0; i < 3; i++) push(2'b00, 3'd1, 8'h20, 8'h05, 8'h15, 8'h03);
    auto_en = 1;
    pulse_req();
    ok = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (done_cnt - base >= 3) begin ok = 1; break; end
    end
    chk("auto_three_done", int'(ok), 1);
    auto_en = 0;
    wait_idle("auto");
    chk("auto_done_count", done_cnt - base, 3);

    // reset during RUN abandons the transaction
    set_modes(M_NORMAL, M_NORMAL);
    base = done_cnt;
    pulse_req();
    wait_wait_high("rstrun");
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    reset_checks("rst_run");
    repeat (2) @(negedge clk);
    rst = 1;
    for (int i = 0; i < 50 && sens_wait; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk("rst_run_no_done", done_cnt - base, 0);
    set_data(8'h11, 8'h22, 8'h05, 8'h06, 8'h3E);
    set_modes(M_NORMAL, M_NORMAL);
    push(2'b00, 3'd1, 8'h11, 8'h22, 8'h05, 8'h06);
    pulse_req();
    wait_idle("after_rst");

    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
